data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 9 +
 rtl/data_memory.sv | 34 +++
 tb/tb_data_memory.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared defaults for the data memory: address width, word width and the word type.
package data_memory_pkg;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

    typedef logic [DATA_W-1:0] word_t;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read gated by MemRead, write of wd on rising clk.
// Zero read latency, one-edge write latency; no backpressure (always accepts).
module data_memory #(
    parameter int DM_ADDRESS = data_memory_pkg::DM_ADDRESS,
    parameter int DATA_W     = data_memory_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd
);

    localparam int DEPTH = 2 ** DM_ADDRESS;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset clears every word asynchronously and blocks writes while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite) begin
            mem_q[a] <= wd;
        end
    end

    // No write-through: a same-address write shows up only after the edge.
    assign rd = MemRead ? mem_q[a] : '0;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-based reference model.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DEPTH = 2 ** DM_ADDRESS;

    logic                  clk;
    logic                  reset;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    word_t                 wd;
    word_t                 rd;

    int n_cmp;
    int n_bad;
    bit chk_en;

    word_t model [DEPTH];

    data_memory #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .a        (a),
        .wd       (wd),
        .rd       (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an array that takes wd on a clean rising edge and is wiped by reset.
    always @(posedge clk) begin
        if (reset === 1'b0 && MemWrite === 1'b1) model[a] = wd;
    end

    always @(posedge reset) begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end

    function automatic word_t exp_rd();
        if (reset === 1'b1 || MemRead !== 1'b1) return '0;
        return model[a];
    endfunction

    always @(posedge clk) begin
        assert (!$isunknown(MemWrite))
            else $error("MemWrite is X/Z at a rising clock edge");
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            word_t e;
            e = exp_rd();
            n_cmp++;
            if (rd !== e) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t a=%0d MemRead=%b rd=%h expected=%h",
                         $time, a, MemRead, rd, e);
            end
        end
    end

    task automatic check(input string name, input word_t exp);
        n_cmp++;
        if (rd !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t rd=%h expected=%h", name, $time, rd, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input word_t data);
        MemWrite = 1'b1;
        MemRead  = 1'b0;
        a        = addr[DM_ADDRESS-1:0];
        wd       = data;
        edge_then_settle();
        MemWrite = 1'b0;
    endtask

    task automatic read_check(input string name, input int addr, input word_t exp);
        MemRead = 1'b1;
        a       = addr[DM_ADDRESS-1:0];
        #1;
        check(name, exp);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        a        = 5;
        wd       = '0;

        #2;
        check("rd_during_reset", 32'h0);
        edge_then_settle();
        edge_then_settle();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset, then read.
        read_check("reset_then_read_a5", 5, 32'h0);

        // Write then read.
        write_word(3, 32'h12345678);
        read_check("write_read_a3", 3, 32'h12345678);

        // Read gating within one cycle.
        MemRead = 1'b0;
        #1;
        check("gate_off_a3", 32'h0);
        MemRead = 1'b1;
        #1;
        check("gate_on_a3", 32'h12345678);

        // Same-address read and write: old word before the edge, new word after.
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        a        = 5;
        wd       = 32'h00700093;
        #1;
        check("same_addr_before_edge", 32'h0);
        edge_then_settle();
        check("same_addr_after_edge", 32'h00700093);
        MemWrite = 1'b0;

        // Address change updates rd combinationally.
        a = 3;
        #1;
        check("addr_change_a3", 32'h12345678);

        // Boundary addresses.
        write_word(0, 32'hDEADBEEF);
        write_word(DEPTH - 1, 32'hCAFEF00D);
        read_check("bound_a0", 0, 32'hDEADBEEF);
        read_check("bound_a511", DEPTH - 1, 32'hCAFEF00D);
        read_check("bound_a1", 1, 32'h0);
        read_check("bound_a510", DEPTH - 2, 32'h0);

        // Asynchronous reset between edges.
        edge_then_settle();
        read_check("pre_reset_a3", 3, 32'h12345678);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_a3", 32'h0);
        a = DEPTH - 1;
        #1;
        check("async_reset_a511", 32'h0);
        #1;
        reset = 1'b0;
        edge_then_settle();
        read_check("post_reset_a3", 3, 32'h0);
        read_check("post_reset_a511", DEPTH - 1, 32'h0);

        // Write ignored while reset is held across the edge.
        MemWrite = 1'b1;
        a        = 9;
        wd       = 32'hA5A5A5A5;
        reset    = 1'b1;
        edge_then_settle();
        reset    = 1'b0;
        MemWrite = 1'b0;
        read_check("reset_wins_a9", 9, 32'h0);

        // First write after reset release lands on the next edge.
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        a        = 9;
        wd       = 32'h0BADF00D;
        #1;
        check("first_write_before_edge", 32'h0);
        edge_then_settle();
        check("first_write_after_edge", 32'h0BADF00D);
        MemWrite = 1'b0;

        // Randomized traffic, mostly in a narrow window so reads hit earlier writes.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel      = int'($urandom_range(0, 99));
            MemRead  = ($urandom_range(0, 3) != 0);
            MemWrite = ($urandom_range(0, 2) == 0);
            if (sel < 70) a = DM_ADDRESS'($urandom_range(0, 15));
            else if (sel < 80) a = DM_ADDRESS'(DEPTH - 1 - $urandom_range(0, 3));
            else a = DM_ADDRESS'($urandom_range(0, DEPTH - 1));
            wd = word_t'($urandom());
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            #1;
            check("random_comb", exp_rd());
            edge_then_settle();
        end

        MemWrite = 1'b0;
        MemRead  = 1'b0;
        edge_then_settle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_memory
